bits2bytes_stream_ctrl: RTL and testbench
=========================================

Name: bits2bytes_stream_ctrl

Overview:
Sequencing controller for the bits2bytes converter in the ByteEncode path. It accepts one polynomial of N_COEFFS d-bit coefficients over a valid/ready stream and packs their bits LSB-first into an N_BYTES*8-bit word. It drives the bits2bytes instance with each completed word and emits the resulting byte vector on a valid/ready output stream. It sits between the compress stage and the byte-serial output buffer.

Parameters:
N_BYTES, 4, bytes per output beat; W = N_BYTES*8 bits per word.
D_MAX, 12, maximum coefficient bit width d.
N_COEFFS, 256, coefficients per polynomial. Must be a multiple of W, so that N_COEFFS*d is always a whole number of words.

Ports:
clk_i  in  1  clock, all state updates on the rising edge.
rst_i  in  1  asynchronous, active-high reset.
start_i  in  1  single-cycle start request; sampled only in IDLE.
d_i  in  4  coefficient width; latched on an accepted start.
busy_o  out  1  high in RUN.
done_o  out  1  one-cycle pulse after the final word handshake.
err_o  out  1  one-cycle pulse when a start is rejected because d is illegal.
coef_valid_i  in  1  coefficient valid.
coef_ready_o  out  1  coefficient ready.
coef_i  in  D_MAX  coefficient; bits [D_MAX-1:d] are ignored.
bytes_valid_o  out  1  output word valid.
bytes_ready_i  in  1  downstream ready.
bytes_o  out  N_BYTES x 8  packed bytes; byte k = word bits [8k+7:8k], taken from the bits2bytes instance.
bytes_last_o  out  1  high with the final word of the polynomial.

Behaviour:
- Reset (asynchronous, rst_i=1) forces:
  - state=IDLE;
  - bit buffer (W+D_MAX-1 bits), fill count, coefficient count and word count all cleared;
  - all outputs 0. bytes_o=0 because the buffer is 0.
- States:
  - IDLE -> RUN on start_i with 1<=d_i<=D_MAX. Latch d, clear all counters.
  - IDLE with start_i and an illegal d_i (0 or >D_MAX): err_o pulses next cycle; state stays IDLE.
  - RUN -> DONE on the handshake of the last word.
  - DONE -> IDLE unconditionally; done_o=1 for exactly that one cycle.
- start_i is ignored outside IDLE.
- coef_ready_o = RUN && fill<W && coef_cnt<N_COEFFS.
- Coefficient handshake (valid&&ready):
  - buffer |= (coef_i & mask(d)) << fill;
  - fill += d;
  - coef_cnt++.
- bytes_valid_o = RUN && fill>=W (registered state, no combinational path from the input stream). The word is buffer[W-1:0], passed through bits2bytes.
- Output handshake: buffer >>= W; fill -= W; word_cnt++.
- Input and output never handshake in the same cycle: ready requires fill<W, valid requires fill>=W.
- Latency: the coefficient that makes fill reach W is accepted on edge t; bytes_valid_o=1 in the cycle after edge t.
- Residual bits (fill-W, at most d-1) stay at buffer LSBs and carry into the next word.
- bytes_last_o = bytes_valid_o && word_cnt == N_COEFFS*d/W - 1.
- Backpressure: while bytes_valid_o && !bytes_ready_i, bytes_o and bytes_last_o hold stable.
- Coefficient/word counters do not wrap. Extra coefficients after N_COEFFS are never accepted (ready=0).
- Reset mid-operation: immediate return to IDLE; no done_o; any partial word is discarded.

Optional Feature:
BITS2BYTES_STREAM_ABORT_EN:
- Defined: adds input port abort_i. abort_i=1 in RUN clears buffer and counters, and the block returns to IDLE on the next edge. No done_o, no err_o. A word that is valid but not yet handshaken is dropped. abort_i has priority over any handshake in the same cycle. abort_i is ignored in IDLE and DONE.
- Not defined: the port is absent; RUN can only end by completion or reset.

Test Plan:
- d=12, all coefficients 0xABC, bytes_ready_i=1:
  - first word bytes_o = {0xBC,0xAB,0xCA,0xBC} (index 3..0);
  - exactly 96 words in total;
  - bytes_last_o on word 96 only; done_o one cycle later.
- d=1, all coefficients 1: 8 words, each 0xFFFFFFFF; bytes_last_o on the 8th.
- d=4, coef_i=0xFF5 for all coefficients: upper bits masked; 32 words, each 0x55555555.
- d=12 with bytes_ready_i held low for 10 cycles on word 1:
  - bytes_o stable throughout and coef_ready_o=0;
  - after release the stream resumes with no lost or duplicated bits (checked against a reference model for random coefficients).
- start_i with d_i=0, then with d_i=13: err_o pulses once for each, busy_o stays 0. start_i pulsed during RUN: no effect.
- Assert rst_i after 100 coefficients with d=10: all outputs 0 immediately. A new start with d=10 then produces 80 correct words.

Source files
------------

// File: rtl/bits2bytes_stream_ctrl_if.sv
// Coefficient-in / byte-word-out stream bundle for
// bits2bytes_stream_ctrl (slave = controller side).
interface bits2bytes_stream_ctrl_if #(
  parameter int N_BYTES = 4,
  parameter int D_MAX   = 12
);
  logic                    coef_valid_i;
  logic                    coef_ready_o;
  logic [D_MAX-1:0]        coef_i;
  logic                    bytes_valid_o;
  logic                    bytes_ready_i;
  logic [N_BYTES-1:0][7:0] bytes_o;
  logic                    bytes_last_o;

  modport slave (
    input  coef_valid_i, coef_i, bytes_ready_i,
    output coef_ready_o, bytes_valid_o, bytes_o, bytes_last_o
  );

  modport master (
    output coef_valid_i, coef_i, bytes_ready_i,
    input  coef_ready_o, bytes_valid_o, bytes_o, bytes_last_o
  );
endinterface

// File: rtl/bits2bytes_stream_ctrl.sv
// Packs d-bit coefficients LSB-first into W-bit words for bits2bytes.
// Optional abort input enabled by BITS2BYTES_STREAM_ABORT_EN.
module bits2bytes_stream_ctrl #(
  parameter int N_BYTES  = 4,
  parameter int D_MAX    = 12,
  parameter int N_COEFFS = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] d_i,
`ifdef BITS2BYTES_STREAM_ABORT_EN
  input  logic       abort_i,
`endif
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  bits2bytes_stream_ctrl_if.slave s
);
  localparam int W   = N_BYTES * 8;
  localparam int BW  = W + D_MAX - 1;
  localparam int FW  = $clog2(BW + 1);
  localparam int CW  = $clog2(N_COEFFS + 1);
  localparam int WPD = N_COEFFS / W;
  localparam int NW  = $clog2(WPD * D_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [BW-1:0]   buf_q;
  logic [FW-1:0]   fill_q;
  logic [CW-1:0]   coef_cnt_q;
  logic [NW-1:0]   word_cnt_q;
  logic [3:0]      d_q;
  logic            err_q;

  logic            run;
  logic            d_ok;
  logic            coef_hs;
  logic            bytes_hs;
  logic            last_w;
  logic [D_MAX-1:0] coef_m;
  logic [BW-1:0]   coef_sh;
  logic [NW-1:0]   n_words;

  assign run    = (state_q == S_RUN);
  assign busy_o = run;
  assign done_o = (state_q == S_DONE);
  assign err_o  = err_q;

  assign d_ok = (d_i != 4'd0) && (d_i <= 4'(D_MAX));

  // Mask off bits at and above d, then place at the fill point.
  assign coef_m  = s.coef_i & ~({D_MAX{1'b1}} << d_q);
  assign coef_sh = BW'(coef_m) << fill_q;

  assign n_words = NW'(WPD) * NW'(d_q);
  assign last_w  = (word_cnt_q == n_words - NW'(1));

  assign s.coef_ready_o  = run && (fill_q < FW'(W))
                         && (coef_cnt_q < CW'(N_COEFFS));
  assign s.bytes_valid_o = run && (fill_q >= FW'(W));
  assign s.bytes_last_o  = s.bytes_valid_o && last_w;

  assign coef_hs  = s.coef_valid_i && s.coef_ready_o;
  assign bytes_hs = s.bytes_valid_o && s.bytes_ready_i;

  // bits2bytes: byte k of the word is word bits [8k+7:8k].
  for (genvar k = 0; k < N_BYTES; k++) begin : g_b2b
    assign s.bytes_o[k] = buf_q[8*k +: 8];
  end

  // Sequencer, bit buffer and counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      fill_q     <= '0;
      coef_cnt_q <= '0;
      word_cnt_q <= '0;
      d_q        <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (d_ok) begin
              state_q    <= S_RUN;
              d_q        <= d_i;
              buf_q      <= '0;
              fill_q     <= '0;
              coef_cnt_q <= '0;
              word_cnt_q <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
`ifdef BITS2BYTES_STREAM_ABORT_EN
          if (abort_i) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            fill_q     <= '0;
            coef_cnt_q <= '0;
            word_cnt_q <= '0;
          end else begin
`else
          begin
`endif
            if (coef_hs) begin
              buf_q      <= buf_q | coef_sh;
              fill_q     <= fill_q + FW'(d_q);
              coef_cnt_q <= coef_cnt_q + CW'(1);
            end else if (bytes_hs) begin
              buf_q      <= buf_q >> W;
              fill_q     <= fill_q - FW'(W);
              word_cnt_q <= word_cnt_q + NW'(1);
              if (last_w) begin
                state_q <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bits2bytes_stream_ctrl.sv
// Directed bench for bits2bytes_stream_ctrl.
// Each test task drives a scenario and checks inline.
module tb_bits2bytes_stream_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] d = 4'd0;
  logic       busy, done, err;
`ifdef BITS2BYTES_STREAM_ABORT_EN
  logic       abort = 1'b0;
`endif

  bits2bytes_stream_ctrl_if #(.N_BYTES(4), .D_MAX(12)) bus();

  bits2bytes_stream_ctrl #(
    .N_BYTES(4), .D_MAX(12), .N_COEFFS(256)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .d_i(d),
`ifdef BITS2BYTES_STREAM_ABORT_EN
    .abort_i(abort),
`endif
    .busy_o(busy),
    .done_o(done),
    .err_o(err),
    .s(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [11:0] coef_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int last_cnt, last_pos, done_gap, done_cnt;
  int stall_cnt, stall_bad, busy_bad;
  bit timeout;

  // Reference packer: LSB-first bit stream cut into 32-bit words.
  task automatic build_exp(input int dd);
    logic [63:0] acc;
    int n;
    acc = '0;
    n = 0;
    exp_q.delete();
    foreach (coef_q[i]) begin
      acc = acc | ((64'(coef_q[i]) & ((64'd1 << dd) - 64'd1)) << n);
      n = n + dd;
      if (n >= 32) begin
        exp_q.push_back(acc[31:0]);
        acc = acc >> 32;
        n = n - 32;
      end
    end
  endtask

  // Start a run, stream coef_q in, collect words out.
  task automatic run_poly(input int dd, input int stall_len,
                          input int stop_after);
    int idx, cyc, last_cyc, stall_left;
    logic [31:0] held;
    bit held_v;
    idx = 0; cyc = 0; last_cyc = -1;
    stall_left = stall_len; held = '0; held_v = 0;
    got_q.delete();
    last_cnt = 0; last_pos = -1; done_gap = -1; done_cnt = 0;
    stall_cnt = 0; stall_bad = 0; busy_bad = 0; timeout = 0;
    start = 1'b1;
    d = 4'(dd);
    @(posedge clk); #1;
    start = 1'b0;
    forever begin
      bus.coef_valid_i = (idx < coef_q.size());
      bus.coef_i = (idx < coef_q.size()) ? coef_q[idx] : 12'h0;
      bus.bytes_ready_i = (stall_left == 0);
      @(negedge clk);
      cyc++;
      if (bus.bytes_valid_o && !bus.bytes_ready_i) begin
        if (held_v && bus.bytes_o !== held) stall_bad++;
        if (bus.coef_ready_o) stall_bad++;
        held = bus.bytes_o;
        held_v = 1;
        stall_left--;
        stall_cnt++;
      end
      if (bus.bytes_valid_o && bus.bytes_ready_i) begin
        got_q.push_back(bus.bytes_o);
        held_v = 0;
        if (bus.bytes_last_o) begin
          last_cnt++;
          last_pos = got_q.size();
          last_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        if (last_cyc >= 0 && done_gap < 0) done_gap = cyc - last_cyc;
      end
      if (last_cyc < 0 && !busy) busy_bad++;
      if (bus.coef_valid_i && bus.coef_ready_o) idx++;
      @(posedge clk); #1;
      if (stop_after > 0 && idx >= stop_after) break;
      if (last_cyc >= 0 && cyc >= last_cyc + 3) break;
      if (cyc > 4000) begin
        timeout = 1;
        break;
      end
    end
    bus.coef_valid_i = 1'b0;
    bus.bytes_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.coef_valid_i = 1'b0;
    bus.coef_i = '0;
    bus.bytes_ready_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_status: got %b%b%b want 000",
               busy, done, err);
    end
    total++;
    if (bus.coef_ready_o !== 1'b0 || bus.bytes_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_stream: got %b%b want 00",
               bus.coef_ready_o, bus.bytes_valid_o);
    end
    total++;
    if (bus.bytes_o !== 32'h0 || bus.bytes_last_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_bytes: got %h/%b want 0/0",
               bus.bytes_o, bus.bytes_last_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_d12();
    int nb;
    coef_q.delete();
    repeat (256) coef_q.push_back(12'hABC);
    build_exp(12);
    run_poly(12, 0, 0);
    total++;
    if (timeout || busy_bad != 0) begin
      bad++;
      $display("FAIL d12_run: timeout %0d busy_bad %0d want 0/0",
               timeout, busy_bad);
    end
    total++;
    if (got_q.size() != 96) begin
      bad++;
      $display("FAIL d12_count: got %0d want 96", got_q.size());
    end
    if (got_q.size() >= 3) begin
      total++;
      if (got_q[0] !== 32'hBCABCABC) begin
        bad++;
        $display("FAIL d12_w0: got %h want bcabcabc", got_q[0]);
      end
      total++;
      if (got_q[1] !== 32'hCABCABCA) begin
        bad++;
        $display("FAIL d12_w1: got %h want cabcabca", got_q[1]);
      end
      total++;
      if (got_q[2] !== 32'hABCABCAB) begin
        bad++;
        $display("FAIL d12_w2: got %h want abcabcab", got_q[2]);
      end
    end
    nb = 0;
    foreach (got_q[i])
      if (i < exp_q.size() && got_q[i] !== exp_q[i]) nb++;
    total++;
    if (nb != 0) begin
      bad++;
      $display("FAIL d12_words: got %0d wrong want 0", nb);
    end
    total++;
    if (last_cnt != 1 || last_pos != 96) begin
      bad++;
      $display("FAIL d12_last: got %0d at %0d want 1 at 96",
               last_cnt, last_pos);
    end
    total++;
    if (done_cnt != 1 || done_gap != 1) begin
      bad++;
      $display("FAIL d12_done: got cnt %0d gap %0d want 1/1",
               done_cnt, done_gap);
    end
  endtask

  task automatic test_d1();
    int nb;
    coef_q.delete();
    repeat (256) coef_q.push_back(12'h001);
    run_poly(1, 0, 0);
    total++;
    if (timeout || got_q.size() != 8) begin
      bad++;
      $display("FAIL d1_count: got %0d to %0d want 8/0",
               got_q.size(), timeout);
    end
    nb = 0;
    foreach (got_q[i]) if (got_q[i] !== 32'hFFFFFFFF) nb++;
    total++;
    if (nb != 0) begin
      bad++;
      $display("FAIL d1_words: got %0d wrong want 0", nb);
    end
    total++;
    if (last_cnt != 1 || last_pos != 8 || done_cnt != 1) begin
      bad++;
      $display("FAIL d1_last: got %0d at %0d done %0d want 1 8 1",
               last_cnt, last_pos, done_cnt);
    end
  endtask

  task automatic test_d4_mask();
    int nb;
    coef_q.delete();
    repeat (256) coef_q.push_back(12'hFF5);
    run_poly(4, 0, 0);
    total++;
    if (timeout || got_q.size() != 32) begin
      bad++;
      $display("FAIL d4_count: got %0d to %0d want 32/0",
               got_q.size(), timeout);
    end
    nb = 0;
    foreach (got_q[i]) if (got_q[i] !== 32'h55555555) nb++;
    total++;
    if (nb != 0) begin
      bad++;
      $display("FAIL d4_mask: got %0d wrong want 0", nb);
    end
    total++;
    if (last_pos != 32) begin
      bad++;
      $display("FAIL d4_last: got %0d want 32", last_pos);
    end
  endtask

  task automatic test_backpressure();
    int nb;
    coef_q.delete();
    repeat (256) coef_q.push_back(12'($urandom));
    build_exp(12);
    run_poly(12, 10, 0);
    total++;
    if (stall_cnt != 10 || stall_bad != 0) begin
      bad++;
      $display("FAIL bp_hold: got stalls %0d bad %0d want 10/0",
               stall_cnt, stall_bad);
    end
    total++;
    if (timeout || got_q.size() != 96) begin
      bad++;
      $display("FAIL bp_count: got %0d to %0d want 96/0",
               got_q.size(), timeout);
    end
    nb = 0;
    foreach (got_q[i])
      if (i < exp_q.size() && got_q[i] !== exp_q[i]) nb++;
    total++;
    if (nb != 0) begin
      bad++;
      $display("FAIL bp_words: got %0d wrong want 0", nb);
    end
  endtask

  task automatic test_err_and_start();
    int eb;
    @(posedge clk); #1;
    start = 1'b1; d = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL err_d0: got err %b busy %b want 1/0", err, busy);
    end
    @(posedge clk); #1;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_d0_pulse: got %b want 0", err);
    end
    start = 1'b1; d = 4'd13;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL err_d13: got err %b busy %b want 1/0", err, busy);
    end
    @(posedge clk); #1;
    total++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL err_d13_pulse: got %b/%b want 0/0", err, busy);
    end
    start = 1'b1; d = 4'd12;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || bus.coef_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL run_enter: got %b/%b want 1/1",
               busy, bus.coef_ready_o);
    end
    eb = 0;
    start = 1'b1; d = 4'd0;
    repeat (3) begin
      @(posedge clk); #1;
      if (err !== 1'b0 || busy !== 1'b1 || done !== 1'b0) eb++;
    end
    start = 1'b0;
    total++;
    if (eb != 0) begin
      bad++;
      $display("FAIL start_in_run: got %0d bad cycles want 0", eb);
    end
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL run_reset: got busy %b want 0", busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    int nb;
    coef_q.delete();
    repeat (256) coef_q.push_back(12'($urandom));
    run_poly(10, 0, 100);
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        bus.coef_ready_o !== 1'b0 || bus.bytes_valid_o !== 1'b0 ||
        bus.bytes_o !== 32'h0 || bus.bytes_last_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got %b%b%b%b%b %h want all 0",
               busy, done, err, bus.coef_ready_o,
               bus.bytes_valid_o, bus.bytes_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    coef_q.delete();
    repeat (256) coef_q.push_back(12'($urandom));
    build_exp(10);
    run_poly(10, 0, 0);
    total++;
    if (timeout || got_q.size() != 80 || last_pos != 80) begin
      bad++;
      $display("FAIL mid_count: got %0d last %0d want 80/80",
               got_q.size(), last_pos);
    end
    nb = 0;
    foreach (got_q[i])
      if (i < exp_q.size() && got_q[i] !== exp_q[i]) nb++;
    total++;
    if (nb != 0) begin
      bad++;
      $display("FAIL mid_words: got %0d wrong want 0", nb);
    end
  endtask

  initial begin
    test_reset();
    test_d12();
    test_d1();
    test_d4_mask();
    test_backpressure();
    test_err_and_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
